// File: rtl/axi_mem_slave_if.sv
// AXI4-style read/write channel bundle between the arbiter master port and
// the backing memory slave.
interface axi_mem_slave_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic [1:0]          arburst;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rlast;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic [1:0]          awburst;
   logic [7:0]          awlen;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic                wlast;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, arburst, arlen, arsize, rready,
      output awaddr, awvalid, awburst, awlen, wdata, wlast, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, arburst, arlen, arsize, rready,
      input  awaddr, awvalid, awburst, awlen, wdata, wlast, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi_mem_slave.sv
// Word-addressed burst memory answering independent AXI4-style read and
// write channels (INCR/FIXED bursts). Memory contents survive reset.
module axi_mem_slave #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 64,
   parameter int                DEPTH     = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
   input logic            clk,
   input logic            rst,
   axi_mem_slave_if.slave bus
);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic       {R_IDLE, R_DATA}         rState_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;

   logic [DATA_W-1:0] mem [DEPTH];

   rState_e           rState_q;
   logic              arready_q, rvalid_q, rlast_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q, rBurst_q;
   logic [ADDR_W-1:0] rAddr_q;
   logic [7:0]        rLen_q, rCnt_q;
   logic [2:0]        rSize_q;

   wState_e           wState_q;
   logic              awready_q, wready_q, bvalid_q, wSlvErr_q, wDecErr_q;
   logic [1:0]        bresp_q, wBurst_q;
   logic [ADDR_W-1:0] wAddr_q;
   logic [7:0]        wLen_q, wCnt_q;

   logic [ADDR_W-1:0] rNextAddr_d, beatAddr;
   logic [7:0]        rCnt_d;
   logic [1:0]        beatBurst, beatResp;
   logic [DATA_W-1:0] beatData;
   logic              wFire, wBeatLast, wBeatUnsup, wBeatOor, wBeatWrite;
   logic              wSlvErr_d, wDecErr_d;
   logic [1:0]        bresp_d;
   logic [IDX_W-1:0]  wIdx;

   function automatic logic inRange(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && ((off >> 3) < ADDR_W'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] wordIdx(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = (addr - BASE_ADDR) >> 3;
      return IDX_W'(off);
   endfunction

   // Pick the read beat to load next: the AR address when idle, otherwise the advanced burst address
   always_comb begin
      rNextAddr_d = (rBurst_q == 2'b01) ? rAddr_q + (ADDR_W'(1) << rSize_q) : rAddr_q;
      rCnt_d      = rCnt_q + 8'd1;
      beatAddr    = (rState_q == R_IDLE) ? bus.araddr  : rNextAddr_d;
      beatBurst   = (rState_q == R_IDLE) ? bus.arburst : rBurst_q;
      beatData    = '0;
      beatResp    = 2'b00;
      if (beatBurst[1]) begin
         beatResp = 2'b10;
      end else if (!inRange(beatAddr)) begin
         beatResp = 2'b11;
      end else begin
         beatData = mem[wordIdx(beatAddr)];
      end
   end

   // Read FSM: accept AR, stream len+1 registered beats, hold them while the master stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rState_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         rBurst_q  <= 2'b00;
         rAddr_q   <= '0;
         rLen_q    <= 8'd0;
         rCnt_q    <= 8'd0;
         rSize_q   <= 3'd0;
      end else begin
         case (rState_q)
            R_IDLE: begin
               if (bus.arvalid && arready_q) begin
                  rAddr_q   <= bus.araddr;
                  rLen_q    <= bus.arlen;
                  rBurst_q  <= bus.arburst;
                  rSize_q   <= bus.arsize;
                  rCnt_q    <= 8'd0;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= beatData;
                  rresp_q   <= beatResp;
                  rlast_q   <= (bus.arlen == 8'd0);
                  rState_q  <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (rvalid_q && bus.rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     rdata_q   <= '0;
                     rresp_q   <= 2'b00;
                     arready_q <= 1'b1;
                     rState_q  <= R_IDLE;
                  end else begin
                     rAddr_q <= rNextAddr_d;
                     rCnt_q  <= rCnt_d;
                     rdata_q <= beatData;
                     rresp_q <= beatResp;
                     rlast_q <= (rCnt_d == rLen_q);
                  end
               end
            end
            default: rState_q <= R_IDLE;
         endcase
      end
   end

   // Classify the current write beat and fold its errors into the sticky burst status
   always_comb begin
      wFire      = (wState_q == W_DATA) && bus.wvalid && wready_q;
      wBeatLast  = (wCnt_q == wLen_q);
      wBeatUnsup = wBurst_q[1];
      wBeatOor   = !wBeatUnsup && !inRange(wAddr_q);
      wBeatWrite = wFire && !wBeatUnsup && !wBeatOor;
      wIdx       = wordIdx(wAddr_q);
      wSlvErr_d  = wSlvErr_q | wBeatUnsup | (bus.wlast != wBeatLast);
      wDecErr_d  = wDecErr_q | wBeatOor;
      bresp_d    = wDecErr_d ? 2'b11 : (wSlvErr_d ? 2'b10 : 2'b00);
   end

   // Write FSM: accept AW, take len+1 beats counted by the slave, then hold the response until bready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wState_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         wSlvErr_q <= 1'b0;
         wDecErr_q <= 1'b0;
         wBurst_q  <= 2'b00;
         wAddr_q   <= '0;
         wLen_q    <= 8'd0;
         wCnt_q    <= 8'd0;
      end else begin
         case (wState_q)
            W_IDLE: begin
               if (bus.awvalid && awready_q) begin
                  wAddr_q   <= bus.awaddr;
                  wLen_q    <= bus.awlen;
                  wBurst_q  <= bus.awburst;
                  wCnt_q    <= 8'd0;
                  wSlvErr_q <= 1'b0;
                  wDecErr_q <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wState_q  <= W_DATA;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            W_DATA: begin
               if (wFire) begin
                  wSlvErr_q <= wSlvErr_d;
                  wDecErr_q <= wDecErr_d;
                  if (wBeatLast) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= bresp_d;
                     wState_q <= W_RESP;
                  end else begin
                     wCnt_q <= wCnt_q + 8'd1;
                     if (wBurst_q == 2'b01) begin
                        wAddr_q <= wAddr_q + ADDR_W'(8);
                     end
                  end
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_q  <= 1'b0;
                  bresp_q   <= 2'b00;
                  awready_q <= 1'b1;
                  wState_q  <= W_IDLE;
               end
            end
            default: wState_q <= W_IDLE;
         endcase
      end
   end

   // Byte-lane write into the store; no reset so contents persist across reset
   always_ff @(posedge clk) begin
      if (wBeatWrite) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrb[b]) begin
               mem[wIdx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
         end
      end
   end

   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign bus.rlast   = rlast_q;
   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave with an array-based memory model.
module tb_axi_mem_slave;
   localparam int          ADDR_W = 32;
   localparam int          DATA_W = 64;
   localparam int          DEPTH  = 4096;
   localparam logic [31:0] BASE   = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;
   logic [63:0] model [DEPTH];

   axi_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   axi_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 ns period
   always #5 clk = ~clk;

   // Hard stop in case a handshake never completes
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic bit outOfRange(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return (addr < BASE) || ((off >> 3) >= 32'(DEPTH));
   endfunction

   function automatic int wordOf(input logic [31:0] addr);
      return int'((addr - BASE) >> 3);
   endfunction

   // Drive one write burst, update the model by the burst rules, and check the response
   task automatic applyStimulusWrite(input logic [31:0] addr, input logic [1:0] burst, input int len,
                                     input logic [63:0] firstData, input logic [7:0] strbIn,
                                     input bit randStrb, input int flipLast);
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      bit          slv, dec;
      int          t;
      slv = 1'b0;
      dec = 1'b0;
      @(negedge clk);
      bus.awaddr  = addr;
      bus.awburst = burst;
      bus.awlen   = 8'(len);
      bus.awvalid = 1'b1;
      t = 0;
      while (!bus.awready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.awready) begin
         checkOutput("awTimeout", 64'd0, 64'd1);
         bus.awvalid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.awvalid = 1'b0;
      checkOutput("awreadyLow", 64'(bus.awready), 64'd0);
      a = addr;
      for (int k = 0; k <= len; k++) begin
         if ($urandom_range(3) == 0) begin
            bus.wvalid = 1'b0;
            @(negedge clk);
         end
         d = (k == 0) ? firstData : {$urandom, $urandom};
         s = randStrb ? 8'($urandom) : strbIn;
         bus.wdata  = d;
         bus.wstrb  = s;
         bus.wlast  = (k == len) ^ (k == flipLast);
         bus.wvalid = 1'b1;
         checkOutput("wready", 64'(bus.wready), 64'd1);
         if (bus.wlast != (k == len)) slv = 1'b1;
         if (burst[1]) begin
            slv = 1'b1;
         end else if (outOfRange(a)) begin
            dec = 1'b1;
         end else begin
            for (int b = 0; b < 8; b++) begin
               if (s[b]) model[wordOf(a)][b*8 +: 8] = d[b*8 +: 8];
            end
         end
         if (burst == 2'b01) a = a + 32'd8;
         @(negedge clk);
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      checkOutput("bvalid", 64'(bus.bvalid), 64'd1);
      checkOutput("bresp", 64'(bus.bresp), dec ? 64'd3 : (slv ? 64'd2 : 64'd0));
      if ($urandom_range(1) == 1) begin
         @(negedge clk);
         checkOutput("bvalidHeld", 64'(bus.bvalid), 64'd1);
         checkOutput("brespHeld", 64'(bus.bresp), dec ? 64'd3 : (slv ? 64'd2 : 64'd0));
      end
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      checkOutput("bvalidDrop", 64'(bus.bvalid), 64'd0);
      checkOutput("awreadyBack", 64'(bus.awready), 64'd1);
   endtask

   // Drive one read burst; stallMode 0 none, 1 alternating rready, 2 random rready
   task automatic applyStimulusRead(input logic [31:0] addr, input logic [1:0] burst, input int len,
                                    input logic [2:0] size, input int stallMode);
      logic [31:0] a;
      logic [63:0] expData;
      logic [1:0]  expResp;
      bit          stall;
      int          t;
      @(negedge clk);
      bus.araddr  = addr;
      bus.arburst = burst;
      bus.arlen   = 8'(len);
      bus.arsize  = size;
      bus.arvalid = 1'b1;
      t = 0;
      while (!bus.arready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.arready) begin
         checkOutput("arTimeout", 64'd0, 64'd1);
         bus.arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.arvalid = 1'b0;
      checkOutput("arreadyLow", 64'(bus.arready), 64'd0);
      a = addr;
      for (int k = 0; k <= len; k++) begin
         if (burst[1]) begin
            expData = 64'd0;
            expResp = 2'b10;
         end else if (outOfRange(a)) begin
            expData = 64'd0;
            expResp = 2'b11;
         end else begin
            expData = model[wordOf(a)];
            expResp = 2'b00;
         end
         stall = (stallMode == 1) ? (k > 0) : ((stallMode == 2) ? bit'($urandom_range(1)) : 1'b0);
         if (stall) begin
            bus.rready = 1'b0;
            checkOutput("rvalidStall", 64'(bus.rvalid), 64'd1);
            @(negedge clk);
         end
         bus.rready = 1'b1;
         checkOutput("rvalid", 64'(bus.rvalid), 64'd1);
         checkOutput("rdata", bus.rdata, expData);
         checkOutput("rresp", 64'(bus.rresp), 64'(expResp));
         checkOutput("rlast", 64'(bus.rlast), 64'(k == len));
         @(negedge clk);
         if (burst == 2'b01) a = a + (32'd1 << size);
      end
      bus.rready = 1'b0;
      checkOutput("rvalidDrop", 64'(bus.rvalid), 64'd0);
      checkOutput("arreadyBack", 64'(bus.arready), 64'd1);
   endtask

   // Directed scenarios followed by a randomized mix of reads and writes
   initial begin
      int          len, w, burstSel, flip;
      bit          isTop;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [31:0] addr;
      bus.arvalid = 1'b0; bus.araddr = '0; bus.arburst = 2'b01; bus.arlen = 8'd0; bus.arsize = 3'd3;
      bus.rready  = 1'b0;
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.awburst = 2'b01; bus.awlen = 8'd0;
      bus.wvalid  = 1'b0; bus.wdata = '0; bus.wstrb = 8'h00; bus.wlast = 1'b0;
      bus.bready  = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetArready", 64'(bus.arready), 64'd0);
      checkOutput("resetAwready", 64'(bus.awready), 64'd0);
      checkOutput("resetRvalid", 64'(bus.rvalid), 64'd0);
      checkOutput("resetWready", 64'(bus.wready), 64'd0);
      checkOutput("resetBvalid", 64'(bus.bvalid), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("arreadyAfterRelease", 64'(bus.arready), 64'd1);
      checkOutput("awreadyAfterRelease", 64'(bus.awready), 64'd1);

      applyStimulusWrite(BASE, 2'b01, 0, 64'h1122334455667788, 8'hFF, 1'b0, -1);
      applyStimulusRead(BASE, 2'b01, 0, 3'd3, 0);

      applyStimulusWrite(BASE + 32'd8, 2'b01, 62, {$urandom, $urandom}, 8'hFF, 1'b0, -1);
      applyStimulusWrite(BASE + 32'd4088 * 8, 2'b01, 7, {$urandom, $urandom}, 8'hFF, 1'b0, -1);

      applyStimulusRead(BASE + 32'd8, 2'b01, 3, 3'd3, 1);

      applyStimulusWrite(BASE, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, -1);
      applyStimulusRead(BASE, 2'b01, 0, 3'd3, 0);

      applyStimulusRead(32'h7FFF_FFF8, 2'b01, 1, 3'd3, 0);
      applyStimulusWrite(BASE + 32'd16, 2'b10, 1, {$urandom, $urandom}, 8'hFF, 1'b0, -1);
      applyStimulusRead(BASE + 32'd16, 2'b01, 1, 3'd3, 0);

      applyStimulusWrite(BASE + 32'd24, 2'b01, 2, {$urandom, $urandom}, 8'hFF, 1'b0, 1);
      applyStimulusRead(BASE + 32'd24, 2'b01, 2, 3'd3, 2);

      applyStimulusRead(BASE + 32'd4094 * 8, 2'b01, 3, 3'd3, 0);
      applyStimulusRead(32'hFFFF_FFF8, 2'b01, 1, 3'd3, 0);
      applyStimulusWrite(BASE + 32'd4093 * 8, 2'b01, 4, {$urandom, $urandom}, 8'hFF, 1'b1, -1);
      applyStimulusRead(BASE + 32'd4090 * 8, 2'b01, 7, 3'd3, 0);

      applyStimulusRead(BASE + 32'd8, 2'b00, 2, 3'd3, 0);
      applyStimulusWrite(BASE + 32'd40, 2'b00, 3, {$urandom, $urandom}, 8'hFF, 1'b1, -1);
      applyStimulusRead(BASE + 32'd40, 2'b01, 0, 3'd3, 0);
      applyStimulusRead(BASE + 32'd3, 2'b01, 5, 3'd1, 2);

      @(negedge clk);
      bus.araddr = BASE; bus.arburst = 2'b01; bus.arlen = 8'd3; bus.arsize = 3'd3; bus.arvalid = 1'b1;
      @(negedge clk);
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      checkOutput("abortArreadyLow", 64'(bus.arready), 64'd0);
      repeat (2) @(negedge clk);
      checkOutput("abortBeat2Valid", 64'(bus.rvalid), 64'd1);
      rst = 1'b0;
      #1;
      checkOutput("abortRvalidReset", 64'(bus.rvalid), 64'd0);
      checkOutput("abortArreadyReset", 64'(bus.arready), 64'd0);
      bus.rready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abortArreadyRelease", 64'(bus.arready), 64'd1);
      applyStimulusRead(BASE, 2'b01, 3, 3'd3, 2);

      fork
         applyStimulusWrite(BASE + 32'd40 * 8, 2'b01, 7, {$urandom, $urandom}, 8'hFF, 1'b1, -1);
         applyStimulusRead(BASE, 2'b01, 7, 3'd3, 2);
      join
      applyStimulusRead(BASE + 32'd40 * 8, 2'b01, 7, 3'd3, 0);

      for (int i = 0; i < 30; i++) begin
         isTop    = ($urandom_range(3) == 0);
         len      = $urandom_range(15);
         burstSel = $urandom_range(9);
         burst    = (burstSel < 6) ? 2'b01 : ((burstSel < 9 || isTop) ? 2'b00 : 2'(2 + $urandom_range(1)));
         w        = isTop ? 4088 + $urandom_range(7) : $urandom_range(48);
         addr     = BASE + 32'(w) * 32'd8;
         if ($urandom_range(1) == 0) begin
            flip = ($urandom_range(4) == 0) ? $urandom_range(len) : -1;
            applyStimulusWrite(addr, burst, len, {$urandom, $urandom}, 8'h00, 1'b1, flip);
         end else begin
            size = 3'($urandom_range(3));
            addr = addr + ((32'($urandom_range(7)) >> size) << size);
            if ($urandom_range(7) == 0) addr = 32'h7FFF_FF00 + 32'($urandom_range(31)) * 32'd8;
            applyStimulusRead(addr, burst, len, size, 2);
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
